lcd_ctrl_de2: RTL
=================

LCD_CTRL_DE2 -- requirements
Module: lcd_ctrl_de2

Interface
REQ-001 SHALL have parameter WAIT_PWR, default 750000: power-up wait in clock cycles (15 ms at 50 MHz).
REQ-002 SHALL have parameter EN_HI, default 25: LCD_EN high time in cycles (500 ns).
REQ-003 SHALL have parameter CMD_WAIT, default 2500: post-byte wait in cycles (50 us).
REQ-004 SHALL have parameter CLR_WAIT, default 82000: post-byte wait for clear (0x01) and home (0x02) commands (1.64 ms).
REQ-005 SHALL have port CLOCK_50, in, 1: the only clock; all logic is on its rising edge.
REQ-006 SHALL have port RESET, in, 1: synchronous, active-high reset.
REQ-007 SHALL have port wr_req, in, 1: byte write request.
REQ-008 SHALL have port wr_rs, in, 1: 0 = command, 1 = character data.
REQ-009 SHALL have port wr_data, in, 8: byte to write.
REQ-010 SHALL have port busy, out, 1: high while a byte or the init sequence is in progress.
REQ-011 SHALL have port init_done, out, 1: high once the init sequence has completed.
REQ-012 SHALL have ports LCD_DATA (out, 8), LCD_RS (out, 1) and LCD_RW (out, 1): HD44780 bus.
REQ-013 SHALL have ports LCD_EN, LCD_ON and LCD_BLON (each out, 1): enable strobe, module power and backlight.

Function
REQ-014 SHALL implement the states PWR_WAIT, SETUP, PULSE, HOLD, WAIT and IDLE.
REQ-015 PWR_WAIT SHALL count WAIT_PWR cycles, then issue the init bytes in order 0x38, 0x0C, 0x01, 0x06, all with RS=0.
REQ-016 Each byte SHALL be sent as: SETUP for 2 cycles (RS/DATA driven, EN=0), then PULSE for EN_HI cycles (EN=1), then HOLD for 2 cycles (EN=0, RS/DATA held), then WAIT.
REQ-017 WAIT SHALL last CLR_WAIT cycles when RS=0 and the byte is 0x01 or 0x02, and CMD_WAIT cycles for any other byte.
REQ-018 After the last init byte's WAIT, init_done SHALL go to 1 and stay at 1 until reset, and the state SHALL go to IDLE.
REQ-019 In IDLE with wr_req=1, wr_rs and wr_data SHALL be captured on that edge and busy SHALL be 1 from the next cycle.
REQ-020 busy SHALL return to 0 on the cycle the state re-enters IDLE.
REQ-021 wr_req SHALL be ignored while busy=1 or init_done=0; no queuing.
REQ-022 A request can be accepted on the first IDLE cycle after a byte completes; back-to-back wr_req SHALL be served without loss.
REQ-023 LCD_RW SHALL be constantly 0 (write only), and LCD_ON and LCD_BLON SHALL be constantly 1.
REQ-024 Every counter SHALL be wide enough for its largest parameter and SHALL never wrap during a phase.

Reset
REQ-025 While RESET=1 the block SHALL hold: state=PWR_WAIT, counters=0, busy=1, init_done=0, LCD_EN=0, LCD_RS=0, LCD_DATA=0x00.
REQ-026 RESET asserted mid-byte or mid-init SHALL abort the transfer on the next edge and restart the full init sequence, including PWR_WAIT.

Configuration
REQ-027 Macro LCD_AUTOWRAP_EN SHALL control automatic line wrapping for a 16x2 display.
REQ-028 With LCD_AUTOWRAP_EN defined, a 5-bit column counter SHALL be kept.
REQ-029 With LCD_AUTOWRAP_EN, the column counter SHALL be cleared by init, clear (0x01) and home (0x02).
REQ-030 With LCD_AUTOWRAP_EN, the column counter SHALL be incremented by each RS=1 byte.
REQ-031 With LCD_AUTOWRAP_EN, after the RS=1 byte at column 15 the block SHALL send command 0xC0 before returning to IDLE.
REQ-032 With LCD_AUTOWRAP_EN, after the RS=1 byte at column 31 the block SHALL send command 0x80 and set the column to 0.
REQ-033 With LCD_AUTOWRAP_EN, busy SHALL stay at 1 through any inserted wrap command.
REQ-034 Without LCD_AUTOWRAP_EN, no counter SHALL exist and no command SHALL be inserted.

Verification
REQ-035 The bench SHALL use parameters WAIT_PWR=20, EN_HI=3, CMD_WAIT=10 and CLR_WAIT=40.
REQ-036 Scenario, reset release -> LCD_EN pulses 4 times with LCD_DATA 0x38, 0x0C, 0x01, 0x06; init_done=1 after the last WAIT.
REQ-037 Scenario, wr_req with RS=1, data 0x41 in IDLE -> busy=1 next cycle; LCD_EN high exactly 3 cycles with LCD_RS=1 and LCD_DATA=0x41; busy=0 after the 10-cycle WAIT.
REQ-038 Scenario, wr_req with RS=0, data 0x01 -> WAIT lasts 40 cycles; wr_req pulses during busy produce no EN pulse.
REQ-039 Scenario, RESET pulse during PULSE of an init byte -> LCD_EN=0 next cycle; init restarts from PWR_WAIT and replays 0x38 first.
REQ-040 Scenario, with LCD_AUTOWRAP_EN, 17 RS=1 writes -> an EN pulse with RS=0, DATA=0xC0 follows the 16th character; the 17th character follows it.
REQ-041 Scenario, without LCD_AUTOWRAP_EN, the same 17 writes -> exactly 17 EN pulses after init, all with RS=1.

Source files
------------

// File: rtl/lcd_ctrl_de2.sv
// HD44780 write-only controller for the DE2 16x2 LCD: power-up wait, init bytes, then single-byte writes.
// Define LCD_AUTOWRAP_EN to track the cursor column and insert line-change commands at 16 and 32 characters.
module lcd_ctrl_de2 #(
    parameter int unsigned WAIT_PWR = 750000,
    parameter int unsigned EN_HI    = 25,
    parameter int unsigned CMD_WAIT = 2500,
    parameter int unsigned CLR_WAIT = 82000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       wr_req,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       init_done,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic       LCD_BLON
);
    localparam int unsigned MAX_AB = (WAIT_PWR > EN_HI) ? WAIT_PWR : EN_HI;
    localparam int unsigned MAX_CD = (CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT;
    localparam int unsigned MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW     = $clog2(MAXP + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(WAIT_PWR - 1);
    localparam logic [CW-1:0] EN_LAST  = CW'(EN_HI - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);
    localparam logic [CW-1:0] TWO_LAST = CW'(1);

    typedef enum logic [2:0] {PWR_WAIT, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    init_idx, init_idx_n;
    logic          init_done_q, init_done_n;
    logic          rs_q, rs_n;
    logic [7:0]    data_q, data_n;
    logic          long_wait;
    logic [CW-1:0] wait_last;
`ifdef LCD_AUTOWRAP_EN
    logic [4:0]    col, col_n;
    logic          wrap_q, wrap_n;
`endif

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    assign long_wait = !rs_q && (data_q == 8'h01 || data_q == 8'h02);
    assign wait_last = long_wait ? CLR_LAST : CMD_LAST;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state       <= PWR_WAIT;
            cnt         <= '0;
            init_idx    <= '0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= '0;
`ifdef LCD_AUTOWRAP_EN
            col         <= '0;
            wrap_q      <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            init_idx    <= init_idx_n;
            init_done_q <= init_done_n;
            rs_q        <= rs_n;
            data_q      <= data_n;
`ifdef LCD_AUTOWRAP_EN
            col         <= col_n;
            wrap_q      <= wrap_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        init_idx_n  = init_idx;
        init_done_n = init_done_q;
        rs_n        = rs_q;
        data_n      = data_q;
`ifdef LCD_AUTOWRAP_EN
        col_n       = col;
        wrap_n      = wrap_q;
`endif
        case (state)
            PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    cnt_n      = '0;
                    state_n    = SETUP;
                    init_idx_n = '0;
                    rs_n       = 1'b0;
                    data_n     = init_byte(2'd0);
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SETUP: begin
                if (cnt == TWO_LAST) begin
                    cnt_n   = '0;
                    state_n = PULSE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PULSE: begin
                if (cnt == EN_LAST) begin
                    cnt_n   = '0;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == TWO_LAST) begin
                    cnt_n   = '0;
                    state_n = WAIT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT: begin
                if (cnt == wait_last) begin
                    cnt_n = '0;
                    if (!init_done_q) begin
                        if (init_idx == 2'd3) begin
                            init_done_n = 1'b1;
                            state_n     = IDLE;
`ifdef LCD_AUTOWRAP_EN
                            col_n       = '0;
`endif
                        end else begin
                            init_idx_n = init_idx + 2'd1;
                            data_n     = init_byte(init_idx + 2'd1);
                            state_n    = SETUP;
                        end
                    end else begin
                        state_n = IDLE;
`ifdef LCD_AUTOWRAP_EN
                        // A character ending a line chains straight into the cursor move, keeping busy high.
                        if (wrap_q) begin
                            wrap_n = 1'b0;
                        end else if (rs_q) begin
                            if (col == 5'd15 || col == 5'd31) begin
                                col_n   = (col == 5'd15) ? 5'd16 : 5'd0;
                                rs_n    = 1'b0;
                                data_n  = (col == 5'd15) ? 8'hC0 : 8'h80;
                                wrap_n  = 1'b1;
                                state_n = SETUP;
                            end else begin
                                col_n = col + 5'd1;
                            end
                        end else if (long_wait) begin
                            col_n = '0;
                        end
`endif
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (wr_req) begin
                    rs_n    = wr_rs;
                    data_n  = wr_data;
                    cnt_n   = '0;
                    state_n = SETUP;
                end
            end
            default: state_n = PWR_WAIT;
        endcase
    end

    assign busy      = (state != IDLE);
    assign init_done = init_done_q;
    assign LCD_EN    = (state == PULSE);
    assign LCD_RS    = rs_q;
    assign LCD_DATA  = data_q;
    assign LCD_RW    = 1'b0;
    assign LCD_ON    = 1'b1;
    assign LCD_BLON  = 1'b1;
endmodule
